// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer plus debounce FSM that turns a bouncy active-low key into a
// clean level with press/release pulses. Define LONG_PRESS_EN to add the hold counter behind Long_Press.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 100000000
) (
   input  logic Clock,
   input  logic Clear,
   input  logic Button_n,
   output logic Clean_n,
   output logic Press_Pulse,
   output logic Release_Pulse,
   output logic Long_Press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   logic             sync1_q;
   logic             sync2_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             clean_n_q;
   logic             press_q;
   logic             release_q;

   // Synchronizer idles at the released level so reset never looks like a press.
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= Button_n;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         clean_n_q <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (!sync2_q) begin
                  state_q <= ARM_PRESS;
                  cnt_q   <= '0;
               end
            end
            ARM_PRESS: begin
               if (sync2_q) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= PRESSED;
                  cnt_q     <= '0;
                  clean_n_q <= 1'b0;
                  press_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (sync2_q) begin
                  state_q <= ARM_RELEASE;
                  cnt_q   <= '0;
               end
            end
            ARM_RELEASE: begin
               // A bounce back to PRESSED is not a new press: level and pulses stay untouched.
               if (!sync2_q) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= RELEASED;
                  cnt_q     <= '0;
                  clean_n_q <= 1'b1;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q   <= RELEASED;
               cnt_q     <= '0;
               clean_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign Clean_n       = clean_n_q;
   assign Press_Pulse   = press_q;
   assign Release_Pulse = release_q;

`ifdef LONG_PRESS_EN
   localparam int              HOLD_W    = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] hold_q;
   logic              long_q;

   // Held at zero until the press is accepted, paused (not cleared) while a release is being qualified.
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if ((state_q == RELEASED) || (state_q == ARM_PRESS)) begin
            hold_q <= '0;
         end else if ((state_q == PRESSED) && (hold_q != HOLD_MAX)) begin
            hold_q <= hold_q + HOLD_W'(1);
            long_q <= (hold_q == HOLD_LAST);
         end
      end
   end

   assign Long_Press = long_q;
`else
   assign Long_Press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scenario tasks plus randomized key traffic checked against a run-length
// reference model of the debouncer (accept a level after DEB+1 consecutive opposite samples).
module tb_button_debouncer;

   localparam int DEB = 4;
   localparam int LNG = 20;
`ifdef LONG_PRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic Clock;
   logic Clear;
   logic Button_n;
   logic Clean_n;
   logic Press_Pulse;
   logic Release_Pulse;
   logic Long_Press;

   int n_tests = 0;
   int n_fail  = 0;

   logic hist_q[$];
   logic m_clean;
   int   m_run;
   int   m_held;
   logic m_press;
   logic m_rel;
   logic m_long;
   int   edge_no;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LNG)
   ) dut (
      .Clock        (Clock),
      .Clear        (Clear),
      .Button_n     (Button_n),
      .Clean_n      (Clean_n),
      .Press_Pulse  (Press_Pulse),
      .Release_Pulse(Release_Pulse),
      .Long_Press   (Long_Press)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [3:0] exp_vec();
      return {m_clean, m_press, m_rel, LP_EN & m_long};
   endfunction

   task automatic model_reset();
      hist_q.delete();
      m_clean = 1'b1;
      m_run   = 0;
      m_held  = 0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      edge_no = 0;
   endtask

   // Drive one button sample, advance one edge, update the model, settle 1 time unit past the edge.
   task automatic tick(input logic b);
      logic s;
      bit   in_pressed;
      Button_n = b;
      @(posedge Clock);
      edge_no++;
      hist_q.push_back(b);
      s = (hist_q.size() >= 3) ? hist_q[hist_q.size()-3] : 1'b1;
      if (hist_q.size() > 3) void'(hist_q.pop_front());
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      in_pressed = (m_clean == 1'b0) && (m_run == 0);
      if (in_pressed && (m_held < LNG)) begin
         m_held++;
         if (m_held == LNG) m_long = 1'b1;
      end
      if (s != m_clean) m_run++;
      else m_run = 0;
      if (m_run == DEB + 1) begin
         m_clean = ~m_clean;
         m_run   = 0;
         if (m_clean == 1'b0) begin
            m_press = 1'b1;
            m_held  = 0;
         end else begin
            m_rel = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      Clear    = 1'b0;
      Button_n = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      Clear = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [3:0] obs;
      Clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         Button_n = 1'($urandom_range(0, 1));
         @(posedge Clock);
         #1;
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got %b want 1000", i, obs);
         end
      end
      Clear = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         tick(1'b1);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
      end
   endtask

   task automatic test_press();
      logic [3:0] obs;
      logic [2:0] want;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick(1'b0);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL press_model edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
         if (edge_no >= 6 && edge_no <= 8) begin
            want = (edge_no == 7) ? 3'b010 : ((edge_no == 6) ? 3'b100 : 3'b000);
            n_tests++;
            if (obs[3:1] !== want) begin
               n_fail++;
               $display("FAIL press_latency edge %0d: got %b want %b", edge_no, obs[3:1], want);
            end
         end
      end
   endtask

   task automatic test_release();
      logic [3:0] obs;
      logic [2:0] want;
      int         start;
      for (int i = 0; i < 8; i++) begin
         tick((i < 2) ? 1'b1 : 1'b0);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec() || obs[3:1] !== 3'b000) begin
            n_fail++;
            $display("FAIL release_glitch edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
      end
      start = edge_no + 1;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL release_model edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
         if (edge_no >= start + 5 && edge_no <= start + 7) begin
            want = (edge_no == start + 6) ? 3'b101 : ((edge_no == start + 5) ? 3'b000 : 3'b100);
            n_tests++;
            if (obs[3:1] !== want) begin
               n_fail++;
               $display("FAIL release_latency edge %0d: got %b want %b", edge_no, obs[3:1], want);
            end
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] obs;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         tick((i < 12 && (i % 4) != 3) ? 1'b0 : 1'b1);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec() || obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL bounce edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] obs;
      logic [1:0] want;
      do_reset();
      repeat (5) tick(1'b0);
      Clear = 1'b0;
      #1;
      obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
      n_tests++;
      if (obs !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b want 1000", obs);
      end
      for (int i = 0; i < 3; i++) begin
         Button_n = 1'b0;
         @(posedge Clock);
         #1;
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid_hold cycle %0d: got %b want 1000", i, obs);
         end
      end
      Clear = 1'b1;
      model_reset();
      for (int i = 0; i < 9; i++) begin
         tick(1'b0);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid_model edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
         if (edge_no == 6 || edge_no == 7) begin
            want = (edge_no == 7) ? 2'b01 : 2'b10;
            n_tests++;
            if (obs[3:2] !== want) begin
               n_fail++;
               $display("FAIL reset_mid_press edge %0d: got %b want %b", edge_no, obs[3:2], want);
            end
         end
      end
   endtask

   task automatic test_long();
      logic [3:0] obs;
      int         n_long;
      int         long_edge;
      do_reset();
      n_long    = 0;
      long_edge = -1;
      for (int i = 0; i < 47; i++) begin
         tick(1'b0);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL long_model edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
         if (Long_Press === 1'b1) begin
            n_long++;
            long_edge = edge_no;
         end
      end
      n_tests++;
      if (n_long != (LP_EN ? 1 : 0)) begin
         n_fail++;
         $display("FAIL long_count: got %0d want %0d", n_long, LP_EN ? 1 : 0);
      end
      n_tests++;
      if (long_edge != (LP_EN ? 27 : -1)) begin
         n_fail++;
         $display("FAIL long_edge: got %0d want %0d", long_edge, LP_EN ? 27 : -1);
      end
      repeat (8) tick(1'b1);
   endtask

   task automatic test_random();
      logic [3:0] obs;
      logic       lvl;
      int         run;
      do_reset();
      lvl = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (run <= 0 || i == 0) begin
            lvl = ~lvl;
            run = $urandom_range(1, 2 * DEB + 3);
         end
         run--;
         tick(lvl);
         obs = {Clean_n, Press_Pulse, Release_Pulse, Long_Press};
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random edge %0d: got %b want %b", edge_no, obs, exp_vec());
         end
         if (Press_Pulse === 1'b1 && Release_Pulse === 1'b1) begin
            n_fail++;
            $display("FAIL random_exclusive edge %0d: got 11 want not both", edge_no);
         end
      end
   endtask

   initial begin
      Clear    = 1'b0;
      Button_n = 1'b1;
      model_reset();
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_reset_mid();
      test_long();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
